flag_cond_unit: RTL and testbench
=================================

FLAG_COND_UNIT -- requirements
Module: flag_cond_unit

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 4, meaning the number of PSR save slots (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port flag_we, input, 1, capture the ALU flags this cycle.
REQ-005 SHALL have port flag_mask, input, 5, per-flag update enable ordered {C,L,F,Z,N}.
REQ-006 SHALL have port flags_in, input, 5, ALU flags {C,L,F,Z,N}.
REQ-007 SHALL have ports psr_wr, input, 1 and psr_wdata, input, 5: direct PSR load.
REQ-008 SHALL have ports psr_push, input, 1 (interrupt entry) and psr_pop, input, 1 (interrupt return).
REQ-009 SHALL have ports cond_valid, input, 1 and cond_code, input, 4: branch condition request.
REQ-010 SHALL have port psr, output, 5, current flags {C,L,F,Z,N}.
REQ-011 SHALL have ports take_valid, output, 1 and take, output, 1: registered branch decision.
REQ-012 SHALL have ports stack_full, output, 1, stack_empty, output, 1 and stack_err, output, 1 (sticky).

Function
REQ-013 SHALL update each PSR bit from flags_in when flag_we=1 and the matching flag_mask bit=1; unmasked bits hold.
REQ-014 SHALL apply same-cycle priority psr_pop > psr_wr > flag_we for the next PSR value.
REQ-015 SHALL, on psr_push with stack not full, store the current registered PSR (pre-update) and increment the pointer.
REQ-016 SHALL, on psr_pop with stack not empty, decrement the pointer and load PSR from the popped slot.
REQ-017 SHALL, on push when full or pop when empty, leave the stack and PSR unchanged and set stack_err.
REQ-018 SHALL, on push and pop asserted together, change neither stack nor PSR-from-stack, set stack_err, and still apply psr_wr/flag_we.
REQ-019 SHALL drive stack_full when pointer=STACK_DEPTH and stack_empty when pointer=0, both combinationally from the pointer.
REQ-020 SHALL evaluate cond_code: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 HI L; 5 LS !L; 6 GT N; 7 LE !N; 8 FS F; 9 FC !F; 10 LO !Z&!L; 11 HS Z|L; 12 LT !N&!Z; 13 GE N|Z; 14 UC 1; 15 never 0.
REQ-021 SHALL register the decision: take_valid=cond_valid and take=evaluated result one cycle after the request; take=0 whenever take_valid=0.
REQ-022 SHALL accept a new condition request every cycle (no back-pressure).

Reset
REQ-023 SHALL, while reset_n=0, force psr=0, pointer=0, take_valid=0, take=0 and stack_err=0, independent of clk.
REQ-024 SHALL clear stack slot contents to 0 on reset; a reset mid-sequence discards all saved PSRs.
REQ-025 SHALL clear stack_err only by reset.

Configuration
REQ-026 SHALL honour macro FLAG_FWD_EN: when defined, conditions are evaluated on the next-PSR value (including same-cycle flag_we/psr_wr/psr_pop); when undefined, on the registered psr only, so a branch needs one cycle after the flag write.

Structure
REQ-027 SHALL take flag bit indices, PSR width (5) and the 16 condition-code constants from shared package flag_pkg.
REQ-028 SHALL contain one combinational sub-module cond_eval (psr, cond_code -> result).

Verification
REQ-029 SHALL cover: flag_we=1, mask=5'b11111, flags_in=5'b00010 -> psr=5'b00010; cond EQ next cycle -> take_valid=1, take=1.
REQ-030 SHALL cover: psr=5'b10000, flag_we=1, mask=5'b00001, flags_in=5'b01111 -> psr=5'b10001.
REQ-031 SHALL cover: STACK_DEPTH=4, five pushes of distinct PSRs -> stack_full after 4th, stack_err=1 after 5th, four pops return them in LIFO order, then stack_empty=1.
REQ-032 SHALL cover: flag_we setting Z=1 with cond EQ in the same cycle -> take=1 with FLAG_FWD_EN, take=0 without.
REQ-033 SHALL cover: reset_n low mid-push sequence with cond_valid=1 -> psr=0, take_valid=0, stack_empty=1, stack_err=0 immediately.

Source files
------------

// File: rtl/flag_pkg.sv
// Shared definitions for the flag/condition unit: PSR layout {C,L,F,Z,N},
// condition-code constants and a masked flag-merge helper.
package flag_pkg;

   localparam int PSR_W  = 5;
   localparam int FLAG_N = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_F = 2;
   localparam int FLAG_L = 3;
   localparam int FLAG_C = 4;

   localparam logic [3:0] CC_EQ = 4'd0;
   localparam logic [3:0] CC_NE = 4'd1;
   localparam logic [3:0] CC_CS = 4'd2;
   localparam logic [3:0] CC_CC = 4'd3;
   localparam logic [3:0] CC_HI = 4'd4;
   localparam logic [3:0] CC_LS = 4'd5;
   localparam logic [3:0] CC_GT = 4'd6;
   localparam logic [3:0] CC_LE = 4'd7;
   localparam logic [3:0] CC_FS = 4'd8;
   localparam logic [3:0] CC_FC = 4'd9;
   localparam logic [3:0] CC_LO = 4'd10;
   localparam logic [3:0] CC_HS = 4'd11;
   localparam logic [3:0] CC_LT = 4'd12;
   localparam logic [3:0] CC_GE = 4'd13;
   localparam logic [3:0] CC_UC = 4'd14;
   localparam logic [3:0] CC_NV = 4'd15;

   // Bits selected by mask come from nxt, the rest keep cur.
   function automatic logic [PSR_W-1:0] merge_flags(input logic [PSR_W-1:0] cur,
                                                    input logic [PSR_W-1:0] nxt,
                                                    input logic [PSR_W-1:0] mask);
      return (cur & ~mask) | (nxt & mask);
   endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational branch-condition evaluator: PSR flags + 4-bit condition
// code -> take/not-take.
module cond_eval
   import flag_pkg::*;
(
   input  logic [PSR_W-1:0] psr_i,
   input  logic [3:0]       cond_code_i,
   output logic             result_o
);

   logic n_s, z_s, f_s, l_s, c_s;

   assign n_s = psr_i[FLAG_N];
   assign z_s = psr_i[FLAG_Z];
   assign f_s = psr_i[FLAG_F];
   assign l_s = psr_i[FLAG_L];
   assign c_s = psr_i[FLAG_C];

   // Condition-code decode.
   always_comb begin
      result_o = 1'b0;
      case (cond_code_i)
         CC_EQ:   result_o = z_s;
         CC_NE:   result_o = ~z_s;
         CC_CS:   result_o = c_s;
         CC_CC:   result_o = ~c_s;
         CC_HI:   result_o = l_s;
         CC_LS:   result_o = ~l_s;
         CC_GT:   result_o = n_s;
         CC_LE:   result_o = ~n_s;
         CC_FS:   result_o = f_s;
         CC_FC:   result_o = ~f_s;
         CC_LO:   result_o = ~z_s & ~l_s;
         CC_HS:   result_o = z_s | l_s;
         CC_LT:   result_o = ~n_s & ~z_s;
         CC_GE:   result_o = n_s | z_s;
         CC_UC:   result_o = 1'b1;
         CC_NV:   result_o = 1'b0;
         default: result_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/flag_cond_unit.sv
// PSR flag register with interrupt save stack and registered branch decision.
// Define FLAG_FWD_EN to evaluate conditions on the next-PSR value (forwarding).
module flag_cond_unit
   import flag_pkg::*;
#(
   parameter int STACK_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flag_we,
   input  logic [PSR_W-1:0] flag_mask,
   input  logic [PSR_W-1:0] flags_in,
   input  logic             psr_wr,
   input  logic [PSR_W-1:0] psr_wdata,
   input  logic             psr_push,
   input  logic             psr_pop,
   input  logic             cond_valid,
   input  logic [3:0]       cond_code,
   output logic [PSR_W-1:0] psr,
   output logic             take_valid,
   output logic             take,
   output logic             stack_full,
   output logic             stack_empty,
   output logic             stack_err
);

   localparam int PTR_W = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = $clog2(STACK_DEPTH);

   logic [PSR_W-1:0] psr_q, psr_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [PSR_W-1:0] stack_q [STACK_DEPTH];
   logic             err_q, err_d;
   logic             take_valid_q, take_q;

   logic             full_s, empty_s, push_ok_s, pop_ok_s, err_set_s, cond_res_s;
   logic [IDX_W-1:0] push_idx_s, pop_idx_s;
   logic [PSR_W-1:0] eval_psr_s;

   assign full_s     = (ptr_q == PTR_W'(STACK_DEPTH));
   assign empty_s    = (ptr_q == {PTR_W{1'b0}});
   assign push_idx_s = ptr_q[IDX_W-1:0];
   assign pop_idx_s  = push_idx_s - IDX_W'(1);

   // Stack legality, pointer and next-PSR selection (pop > wr > flag_we).
   always_comb begin
      push_ok_s = psr_push & ~psr_pop & ~full_s;
      pop_ok_s  = psr_pop & ~psr_push & ~empty_s;
      err_set_s = (psr_push & psr_pop) | (psr_push & full_s) | (psr_pop & empty_s);
      err_d     = err_q | err_set_s;

      if (push_ok_s) begin
         ptr_d = ptr_q + PTR_W'(1);
      end else if (pop_ok_s) begin
         ptr_d = ptr_q - PTR_W'(1);
      end else begin
         ptr_d = ptr_q;
      end

      if (pop_ok_s) begin
         psr_d = stack_q[pop_idx_s];
      end else if (psr_wr) begin
         psr_d = psr_wdata;
      end else if (flag_we) begin
         psr_d = merge_flags(psr_q, flags_in, flag_mask);
      end else begin
         psr_d = psr_q;
      end
   end

`ifdef FLAG_FWD_EN
   assign eval_psr_s = psr_d;
`else
   assign eval_psr_s = psr_q;
`endif

   cond_eval u_cond_eval (
      .psr_i       (eval_psr_s),
      .cond_code_i (cond_code),
      .result_o    (cond_res_s)
   );

   // State registers; reset also wipes every saved PSR.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         psr_q        <= {PSR_W{1'b0}};
         ptr_q        <= {PTR_W{1'b0}};
         err_q        <= 1'b0;
         take_valid_q <= 1'b0;
         take_q       <= 1'b0;
         for (int i = 0; i < STACK_DEPTH; i++) begin
            stack_q[i] <= {PSR_W{1'b0}};
         end
      end else begin
         psr_q        <= psr_d;
         ptr_q        <= ptr_d;
         err_q        <= err_d;
         take_valid_q <= cond_valid;
         take_q       <= cond_valid & cond_res_s;
         if (push_ok_s) begin
            stack_q[push_idx_s] <= psr_q;
         end
      end
   end

   assign psr         = psr_q;
   assign take_valid  = take_valid_q;
   assign take        = take_q;
   assign stack_full  = full_s;
   assign stack_empty = empty_s;
   assign stack_err   = err_q;

endmodule

// File: tb/tb_flag_cond_unit.sv
// Self-checking bench for flag_cond_unit: directed scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_flag_cond_unit;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       flag_we = 1'b0;
   logic [4:0] flag_mask = 5'd0;
   logic [4:0] flags_in = 5'd0;
   logic       psr_wr = 1'b0;
   logic [4:0] psr_wdata = 5'd0;
   logic       psr_push = 1'b0;
   logic       psr_pop = 1'b0;
   logic       cond_valid = 1'b0;
   logic [3:0] cond_code = 4'd0;
   logic [4:0] psr;
   logic       take_valid, take, stack_full, stack_empty, stack_err;

   int n_cmp = 0;
   int n_bad = 0;

   logic [4:0] m_psr;
   logic [4:0] m_stk[$];
   logic       m_err, m_tv, m_tk;

   flag_cond_unit #(.STACK_DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .flag_we(flag_we), .flag_mask(flag_mask),
      .flags_in(flags_in), .psr_wr(psr_wr), .psr_wdata(psr_wdata),
      .psr_push(psr_push), .psr_pop(psr_pop), .cond_valid(cond_valid),
      .cond_code(cond_code), .psr(psr), .take_valid(take_valid), .take(take),
      .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
   );

   always #5 clk = ~clk;

   function automatic logic cond_of(input logic [4:0] p, input logic [3:0] cc);
      logic c, l, f, z, n;
      {c, l, f, z, n} = p;
      case (cc)
         4'd0: return z;          4'd1: return !z;
         4'd2: return c;          4'd3: return !c;
         4'd4: return l;          4'd5: return !l;
         4'd6: return n;          4'd7: return !n;
         4'd8: return f;          4'd9: return !f;
         4'd10: return !z && !l;  4'd11: return z || l;
         4'd12: return !n && !z;  4'd13: return n || z;
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      chk("psr", 32'(psr), 32'(m_psr));
      chk("take_valid", 32'(take_valid), 32'(m_tv));
      chk("take", 32'(take), 32'(m_tk));
      chk("stack_full", 32'(stack_full), 32'(m_stk.size() == DEPTH));
      chk("stack_empty", 32'(stack_empty), 32'(m_stk.size() == 0));
      chk("stack_err", 32'(stack_err), 32'(m_err));
   endtask

   task automatic model_reset();
      m_psr = 5'd0;
      m_stk.delete();
      m_err = 1'b0;
      m_tv  = 1'b0;
      m_tk  = 1'b0;
   endtask

   // Applies one clock of the specified behaviour to the model.
   task automatic model_step();
      logic [4:0] nxt;
      logic       popped;
      logic [4:0] pv;
      popped = 1'b0;
      pv = 5'd0;
      if (psr_push && psr_pop) begin
         m_err = 1'b1;
      end else if (psr_push) begin
         if (m_stk.size() == DEPTH) m_err = 1'b1;
         else m_stk.push_back(m_psr);
      end else if (psr_pop) begin
         if (m_stk.size() == 0) m_err = 1'b1;
         else begin
            pv = m_stk.pop_back();
            popped = 1'b1;
         end
      end
      if (popped) nxt = pv;
      else if (psr_wr) nxt = psr_wdata;
      else if (flag_we) nxt = (m_psr & ~flag_mask) | (flags_in & flag_mask);
      else nxt = m_psr;
`ifdef FLAG_FWD_EN
      m_tk = cond_valid && cond_of(nxt, cond_code);
`else
      m_tk = cond_valid && cond_of(m_psr, cond_code);
`endif
      m_tv = cond_valid;
      m_psr = nxt;
   endtask

   task automatic idle();
      flag_we = 1'b0; flag_mask = 5'd0; flags_in = 5'd0;
      psr_wr = 1'b0; psr_wdata = 5'd0; psr_push = 1'b0; psr_pop = 1'b0;
      cond_valid = 1'b0; cond_code = 4'd0;
   endtask

   // Inputs are driven at the falling edge; outputs checked at the next one.
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_model();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      model_reset();
      #1;
      check_model();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   logic [4:0] vals [5];

   initial begin
      vals[0] = 5'h03; vals[1] = 5'h0C; vals[2] = 5'h11; vals[3] = 5'h1E; vals[4] = 5'h15;
      model_reset();
      #3;
      check_model();
      chk("reset_psr", 32'(psr), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Full mask write sets only Z; EQ then taken.
      flag_we = 1'b1; flag_mask = 5'b11111; flags_in = 5'b00010;
      cycle();
      chk("full_mask_psr", 32'(psr), 32'h02);
      idle(); cond_valid = 1'b1; cond_code = 4'd0;
      cycle();
      chk("eq_take_valid", 32'(take_valid), 32'd1);
      chk("eq_take", 32'(take), 32'd1);

      // Masked write touches only N.
      idle(); psr_wr = 1'b1; psr_wdata = 5'b10000;
      cycle();
      idle(); flag_we = 1'b1; flag_mask = 5'b00001; flags_in = 5'b01111;
      cycle();
      chk("masked_psr", 32'(psr), 32'h11);

      // Five pushes of distinct PSRs, then LIFO pops.
      for (int i = 0; i < 5; i++) begin
         idle(); psr_wr = 1'b1; psr_wdata = vals[i];
         cycle();
         idle(); psr_push = 1'b1;
         cycle();
         if (i == 3) begin
            chk("full_after_4", 32'(stack_full), 32'd1);
            chk("no_err_after_4", 32'(stack_err), 32'd0);
         end
      end
      chk("err_after_5", 32'(stack_err), 32'd1);
      for (int i = 0; i < 4; i++) begin
         idle(); psr_pop = 1'b1;
         cycle();
         chk("lifo_pop", 32'(psr), 32'(vals[3-i]));
      end
      chk("empty_after_pops", 32'(stack_empty), 32'd1);

      // Same-cycle Z set with EQ request.
      idle(); psr_wr = 1'b1; psr_wdata = 5'd0;
      cycle();
      idle(); flag_we = 1'b1; flag_mask = 5'b00010; flags_in = 5'b00010;
      cond_valid = 1'b1; cond_code = 4'd0;
      cycle();
      chk("fwd_take_valid", 32'(take_valid), 32'd1);
`ifdef FLAG_FWD_EN
      chk("fwd_take", 32'(take), 32'd1);
`else
      chk("fwd_take", 32'(take), 32'd0);
`endif

      // Reset in the middle of a push sequence.
      idle(); psr_wr = 1'b1; psr_wdata = 5'h1F;
      cycle();
      idle(); psr_push = 1'b1; cond_valid = 1'b1; cond_code = 4'd14;
      cycle();
      cycle();
      @(posedge clk);
      model_step();
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("rst_psr", 32'(psr), 32'd0);
      chk("rst_take_valid", 32'(take_valid), 32'd0);
      chk("rst_empty", 32'(stack_empty), 32'd1);
      chk("rst_err", 32'(stack_err), 32'd0);
      @(negedge clk);
      check_model();
      idle();
      reset_n = 1'b1;

      // Randomized traffic.
      for (int k = 0; k < 3000; k++) begin
         if (k % 400 == 399) begin
            do_reset();
         end
         flag_we    = ($urandom_range(0, 2) == 0);
         flag_mask  = 5'($urandom);
         flags_in   = 5'($urandom);
         psr_wr     = ($urandom_range(0, 5) == 0);
         psr_wdata  = 5'($urandom);
         psr_push   = ($urandom_range(0, 2) == 0);
         psr_pop    = ($urandom_range(0, 2) == 0);
         cond_valid = ($urandom_range(0, 3) != 0);
         cond_code  = 4'($urandom);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
